// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: in-flight writer scoreboard driving ID stall, per-port forwarding selects and MD busy tracking.
// Optional HAZARD_PERF_EN adds stall_cnt/md_stall_cnt performance counters.
module hazard_scoreboard #(
  parameter int NUM_RD  = 2,
  parameter int STAGES  = 3,
  parameter int AW      = 5,
  parameter int TW      = 2,
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10,
  localparam int SW     = $clog2(STAGES + 1),
  localparam int FW     = SW + 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 id_valid,
  input  logic [NUM_RD*AW-1:0] id_ra,
  input  logic [NUM_RD*TW-1:0] id_tuse,
  input  logic [AW-1:0]        id_wa,
  input  logic [TW-1:0]        id_tnew,
  input  logic [1:0]           id_src,
  input  logic                 id_md_use,
  input  logic                 md_start,
  input  logic                 md_is_div,
  input  logic                 flush,
  output logic                 stall,
  output logic [NUM_RD*FW-1:0] fwd_sel,
`ifdef HAZARD_PERF_EN
  output logic [31:0]          stall_cnt,
  output logic [31:0]          md_stall_cnt,
`endif
  output logic                 md_busy
);
  localparam int MAXL = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW   = $clog2(MAXL + 1);
  logic          v    [STAGES];
  logic [AW-1:0] wa   [STAGES];
  logic [TW-1:0] tnew [STAGES];
  logic [1:0]    src  [STAGES];
  logic [CW-1:0] cnt;
  logic [NUM_RD-1:0] hz;
  logic md_hz;
  assign md_busy = cnt != '0;
  // Entry 0 takes the ID instruction; older entries age by one stage and count Tnew down to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        v[k]    <= 1'b0;
        wa[k]   <= '0;
        tnew[k] <= '0;
        src[k]  <= '0;
      end
      cnt <= '0;
    end else if (flush) begin
      for (int k = 0; k < STAGES; k++) v[k] <= 1'b0;
      cnt <= '0;
    end else begin
      v[0]    <= !stall && id_valid && id_wa != '0;
      wa[0]   <= id_wa;
      tnew[0] <= id_tnew;
      src[0]  <= id_src;
      for (int k = 1; k < STAGES; k++) begin
        v[k]    <= v[k-1];
        wa[k]   <= wa[k-1];
        tnew[k] <= tnew[k-1] == '0 ? '0 : tnew[k-1] - 1'b1;
        src[k]  <= src[k-1];
      end
      cnt <= md_start ? (md_is_div ? CW'(DIV_LAT) : CW'(MUL_LAT)) : cnt - CW'(md_busy);
    end
  end
  // Youngest match wins; a not-yet-ready writer within the reader's Tuse is forwarded later downstream.
  always_comb begin
    logic [AW-1:0] ra;
    logic [TW-1:0] tu;
    logic          found;
    hz      = '0;
    fwd_sel = '0;
    ra      = '0;
    tu      = '0;
    found   = 1'b0;
    for (int i = 0; i < NUM_RD; i++) begin
      ra    = id_ra[i*AW +: AW];
      tu    = id_tuse[i*TW +: TW];
      found = 1'b0;
      for (int k = 0; k < STAGES; k++) begin
        if (!found && id_valid && ra != '0 && v[k] && wa[k] == ra) begin
          found = 1'b1;
          if (tnew[k] > tu) hz[i] = 1'b1;
          else if (tnew[k] == '0) fwd_sel[i*FW +: FW] = {SW'(k + 1), src[k]};
        end
      end
    end
    md_hz = id_md_use && (md_busy || md_start);
    stall = id_valid && (|hz || md_hz);
  end
`ifdef HAZARD_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt    <= '0;
      md_stall_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= stall_cnt + 32'd1;
      if (stall && !(|hz)) md_stall_cnt <= md_stall_cnt + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_hazard_scoreboard.sv
// tb_hazard_scoreboard: directed scenarios with queued expectations for hazard_scoreboard.
module tb_hazard_scoreboard;
  logic clk = 1'b0;
  logic rst_n;
  logic id_valid, id_md_use, md_start, md_is_div, flush;
  logic [9:0] id_ra;
  logic [3:0] id_tuse;
  logic [4:0] id_wa;
  logic [1:0] id_tnew, id_src;
  logic stall, md_busy;
  logic [7:0] fwd_sel;
`ifdef HAZARD_PERF_EN
  logic [31:0] stall_cnt, md_stall_cnt;
`endif
  logic [9:0] exp_q [$];
  string tag_q [$];
  int checks = 0;
  int errors = 0;

  hazard_scoreboard dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_ra(id_ra), .id_tuse(id_tuse),
    .id_wa(id_wa), .id_tnew(id_tnew), .id_src(id_src), .id_md_use(id_md_use),
    .md_start(md_start), .md_is_div(md_is_div), .flush(flush), .stall(stall),
    .fwd_sel(fwd_sel),
`ifdef HAZARD_PERF_EN
    .stall_cnt(stall_cnt), .md_stall_cnt(md_stall_cnt),
`endif
    .md_busy(md_busy)
  );

  always #5 clk = ~clk;

  task automatic idle();
    id_valid = 0; id_ra = '0; id_tuse = '0; id_wa = '0; id_tnew = '0; id_src = '0;
    id_md_use = 0; md_start = 0; md_is_div = 0; flush = 0;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic expect_out(input string tag, input logic s, input logic [7:0] f, input logic b);
    exp_q.push_back({s, f, b});
    tag_q.push_back(tag);
  endtask

  task automatic check();
    logic [9:0] e;
    string t;
    #1;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      checks++;
      assert ({stall, fwd_sel, md_busy} === e) else begin
        errors++;
        $error("FAIL %s: got stall=%0b fwd=%h busy=%0b, want stall=%0b fwd=%h busy=%0b",
               t, stall, fwd_sel, md_busy, e[9], e[8:1], e[0]);
      end
    end
  endtask

  task automatic issue(input logic [4:0] wa, input logic [1:0] tn, input logic [1:0] sr);
    id_valid = 1; id_wa = wa; id_tnew = tn; id_src = sr;
  endtask

  task automatic read(input logic [4:0] r0, input logic [1:0] t0, input logic [4:0] r1, input logic [1:0] t1);
    id_valid = 1; id_ra = {r1, r0}; id_tuse = {t1, t0};
  endtask

  initial begin
    rst_n = 0;
    idle();
    #3;
    expect_out("reset", 0, 8'h00, 0);
    check();
    @(negedge clk);
    rst_n = 1;
    // load-use: lw $8 tnew=2 DM, reader tuse=0
    nxt(); issue(8, 2, 3); expect_out("lu_issue", 0, 8'h00, 0); check();
    nxt(); read(8, 0, 0, 0); expect_out("lu_stall1", 1, 8'h00, 0); check();
    nxt(); read(8, 0, 0, 0); expect_out("lu_stall2", 1, 8'h00, 0); check();
    nxt(); read(8, 0, 0, 0); expect_out("lu_fwd", 0, 8'h0F, 0); check();
    // ALU back-to-back
    nxt(); issue(3, 1, 0); expect_out("alu_issue", 0, 8'h00, 0); check();
    nxt(); read(0, 0, 3, 1); expect_out("alu_tuse1", 0, 8'h00, 0); check();
    nxt(); read(3, 0, 3, 0); expect_out("alu_fwd2", 0, 8'h88, 0); check();
    // shadowing: older ALU writer hidden by younger PC8 writer
    nxt(); issue(5, 0, 0); expect_out("sh_issue_alu", 0, 8'h00, 0); check();
    nxt(); issue(5, 0, 1); read(5, 0, 0, 0); expect_out("sh_single", 0, 8'h04, 0); check();
    nxt(); read(5, 0, 5, 3); expect_out("sh_youngest", 0, 8'h55, 0); check();
    // $0 / no-write / invalid ID
    nxt(); issue(0, 0, 0); expect_out("zero_issue", 0, 8'h00, 0); check();
    nxt(); id_ra = {5'd0, 5'd5}; expect_out("id_invalid", 0, 8'h00, 0); check();
    nxt(); read(0, 0, 0, 0); expect_out("zero_read", 0, 8'h00, 0); check();
    // divide busy window
    nxt(); id_valid = 1; id_md_use = 1; md_start = 1; md_is_div = 1;
    expect_out("div_start", 1, 8'h00, 0); check();
    for (int i = 0; i < 10; i++) begin
      nxt(); id_valid = 1; id_md_use = 1; expect_out("div_busy", 1, 8'h00, 1); check();
    end
    nxt(); id_valid = 1; id_md_use = 1; expect_out("div_release", 0, 8'h00, 0); check();
    // multiply busy window, no MD user in ID
    nxt(); id_valid = 1; md_start = 1; expect_out("mul_start", 0, 8'h00, 0); check();
    for (int i = 0; i < 5; i++) begin
      nxt(); expect_out("mul_busy", 0, 8'h00, 1); check();
    end
    nxt(); expect_out("mul_done", 0, 8'h00, 0); check();
    // flush beats issue and md_start
    nxt(); issue(7, 0, 0); md_start = 1; md_is_div = 1; flush = 1;
    expect_out("flush_cycle", 0, 8'h00, 0); check();
    nxt(); read(7, 0, 0, 0); id_md_use = 1; expect_out("after_flush", 0, 8'h00, 0); check();
    // async reset drops a state-caused stall
    nxt(); issue(10, 2, 3); expect_out("rs_issue", 0, 8'h00, 0); check();
    nxt(); read(10, 0, 0, 0); expect_out("rs_stall", 1, 8'h00, 0); check();
    rst_n = 0;
    #1;
    expect_out("rs_async", 0, 8'h00, 0); check();
    @(negedge clk);
    rst_n = 1;
    // Tnew vs nonzero Tuse
    nxt(); issue(8, 2, 3); expect_out("tu_issue", 0, 8'h00, 0); check();
    nxt(); read(8, 1, 0, 0); expect_out("tu_stall", 1, 8'h00, 0); check();
    nxt(); read(0, 0, 8, 1); expect_out("tu_later", 0, 8'h00, 0); check();
    nxt(); read(0, 0, 8, 0); expect_out("tu_fwd3", 0, 8'hF0, 0); check();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
